// File: rtl/servo_pkg.sv
// Shared helpers for the servo PWM bank: width math and tick derivation.
// SERVO_SLEW_EN selects rate-limited position updates instead of immediate jumps.
package servo_pkg;

  function automatic int unsigned clog2(input longint unsigned v);
    int unsigned r = 0;
    longint unsigned p = 1;
    while (p < v) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int unsigned frame_ticks(input longint unsigned clk_hz,
                                              input longint unsigned frame_hz);
    return 32'(clk_hz / frame_hz);
  endfunction

  function automatic int unsigned min_ticks(input longint unsigned clk_hz,
                                            input longint unsigned min_us);
    return 32'((clk_hz * min_us) / 64'd1_000_000);
  endfunction

  function automatic int unsigned step_ticks(input longint unsigned clk_hz,
                                             input longint unsigned min_us,
                                             input longint unsigned max_us,
                                             input int unsigned     duty_w);
    return 32'((((max_us - min_us) * clk_hz) / 64'd1_000_000) /
               ((64'd1 << duty_w) - 64'd1));
  endfunction

  // Largest per-frame code change; full scale means "jump straight to target".
  function automatic int unsigned slew_limit(input int unsigned slew_step,
                                             input int unsigned duty_w,
                                             input bit          en);
    longint unsigned full;
    full = (64'd1 << duty_w) - 64'd1;
    if (!en || 64'(slew_step) > full) return 32'(full);
    return slew_step;
  endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo channel: target/active position registers, per-frame update and
// the registered pulse comparator. SERVO_SLEW_EN enables rate-limited updates.
module servo_pwm_channel
  import servo_pkg::*;
#(
  parameter int unsigned DUTY_W     = 8,
  parameter int unsigned TICKS_W    = 10,
  parameter int unsigned MIN_TICKS  = 100,
  parameter int unsigned STEP_TICKS = 1,
  parameter int unsigned RESET_DUTY = 128,
  parameter int unsigned SLEW_STEP  = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               boundary,
  input  logic               wr_en,
  input  logic [DUTY_W-1:0]  wr_data,
  input  logic [TICKS_W-1:0] cnt,
  output logic               pwm_out
);

  typedef logic [DUTY_W-1:0] duty_t;

`ifdef SERVO_SLEW_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif

  localparam int unsigned PROD_W = DUTY_W + 32;
  localparam duty_t       MAX_STEP = duty_t'(slew_limit(SLEW_STEP, DUTY_W, SLEW_EN));

  duty_t              target;
  duty_t              active;
  duty_t              active_nxt;
  duty_t              diff;
  duty_t              step;
  logic [PROD_W-1:0]  width;

  // Move active toward target, never overshooting.
  always_comb begin
    diff       = (target >= active) ? (target - active) : (active - target);
    step       = (diff > MAX_STEP) ? MAX_STEP : diff;
    active_nxt = (target >= active) ? (active + step) : (active - step);
  end

  assign width = PROD_W'(MIN_TICKS) + PROD_W'(active) * PROD_W'(STEP_TICKS);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      target  <= duty_t'(RESET_DUTY);
      active  <= duty_t'(RESET_DUTY);
      pwm_out <= 1'b0;
    end else begin
      if (wr_en)    target <= wr_data;
      if (boundary) active <= active_nxt;
      pwm_out <= (PROD_W'(cnt) < width);
    end
  end

endmodule

// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM generator: shared frame counter, load edge detect and
// address decode feeding one servo_pwm_channel per output (SERVO_SLEW_EN optional).
module servo_pwm_bank
  import servo_pkg::*;
#(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned DUTY_W     = 8,
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned FRAME_HZ   = 50,
  parameter int unsigned MIN_US     = 1000,
  parameter int unsigned MAX_US     = 2000,
  parameter int unsigned RESET_DUTY = 128,
  parameter int unsigned SLEW_STEP  = 4,
  localparam int unsigned AW = (clog2(64'(CHANNELS)) > 0) ? clog2(64'(CHANNELS)) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic [AW-1:0]       servo_address,
  input  logic [DUTY_W-1:0]   switch_duty_cycle,
  output logic [CHANNELS-1:0] servo_pwm_out,
  output logic                frame_start
);

  localparam int unsigned FRAME_TICKS = frame_ticks(64'(CLK_HZ), 64'(FRAME_HZ));
  localparam int unsigned MIN_TICKS   = min_ticks(64'(CLK_HZ), 64'(MIN_US));
  localparam int unsigned STEP_TICKS  = step_ticks(64'(CLK_HZ), 64'(MIN_US), 64'(MAX_US), DUTY_W);
  localparam int unsigned TICKS_W     = (clog2(64'(FRAME_TICKS)) > 0) ? clog2(64'(FRAME_TICKS)) : 1;

  logic [TICKS_W-1:0] cnt;
  logic               load_q;
  logic               wr_fire;
  logic               boundary;

  assign wr_fire  = load & ~load_q;
  assign boundary = (cnt == TICKS_W'(FRAME_TICKS - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      load_q      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= boundary ? '0 : cnt + TICKS_W'(1);
      load_q      <= load;
      frame_start <= (cnt == '0);
    end
  end

  // Address decode: out-of-range addresses match no channel and are dropped.
  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    servo_pwm_channel #(
      .DUTY_W     (DUTY_W),
      .TICKS_W    (TICKS_W),
      .MIN_TICKS  (MIN_TICKS),
      .STEP_TICKS (STEP_TICKS),
      .RESET_DUTY (RESET_DUTY),
      .SLEW_STEP  (SLEW_STEP)
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .boundary (boundary),
      .wr_en    (wr_fire && (servo_address == AW'(i))),
      .wr_data  (switch_duty_cycle),
      .cnt      (cnt),
      .pwm_out  (servo_pwm_out[i])
    );
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Self-checking bench for servo_pwm_bank: frame-level reference model of target/
// active codes; measures per-frame high time of every output.
module tb_servo_pwm_bank;

  localparam int CH    = 4;
  localparam int FT    = 1000;
  localparam int MINT  = 100;
  localparam int STEPT = 1;
  localparam int RDUTY = 128;
  localparam int SLEW  = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          load;
  logic [1:0]    servo_address;
  logic [7:0]    switch_duty_cycle;
  logic [CH-1:0] servo_pwm_out;
  logic          frame_start;

  always #5 clock = ~clock;

  servo_pwm_bank #(
    .CHANNELS   (CH),
    .DUTY_W     (8),
    .CLK_HZ     (1_000_000),
    .FRAME_HZ   (1000),
    .MIN_US     (100),
    .MAX_US     (355),
    .RESET_DUTY (RDUTY),
    .SLEW_STEP  (SLEW)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .load              (load),
    .servo_address     (servo_address),
    .switch_duty_cycle (switch_duty_cycle),
    .servo_pwm_out     (servo_pwm_out),
    .frame_start       (frame_start)
  );

  typedef struct {int c; int addr; int data;} wr_t;

  int  tgt [CH];
  int  act [CH];
  int  meas[CH];
  bit  prev_load;
  bit  hold_load;
  wr_t evq[$];
  int  errors = 0;
  int  checks = 0;
  int  slew_w[4];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int next_active(input int t, input int a);
`ifdef SERVO_SLEW_EN
    if (t > a) return (t - a > SLEW) ? a + SLEW : t;
    return (a - t > SLEW) ? a - SLEW : t;
`else
    return t;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      tgt[i] = RDUTY;
      act[i] = RDUTY;
    end
    prev_load = 1'b0;
  endtask

  task automatic add_wr(input int c, input int addr, input int data);
    wr_t w;
    w.c = c; w.addr = addr; w.data = data;
    evq.push_back(w);
  endtask

  // Runs cnt = 0..stop_at-1; starts at the negedge before the cnt=0 posedge.
  task automatic run_frame(input int stop_at, input string tag);
    int exp_w[CH];
    int hi[CH];
    int fs_cnt;
    int fs_pos;
    fs_cnt = 0;
    fs_pos = -1;
    for (int i = 0; i < CH; i++) begin
      exp_w[i] = MINT + act[i] * STEPT;
      hi[i]    = 0;
    end
    for (int c = 0; c < stop_at; c++) begin
      load              = 1'b0;
      servo_address     = 2'($urandom);
      switch_duty_cycle = 8'($urandom);
      if (hold_load) load = 1'b1;
      foreach (evq[k]) begin
        if (evq[k].c == c) begin
          load              = 1'b1;
          servo_address     = 2'(evq[k].addr);
          switch_duty_cycle = 8'(evq[k].data);
        end
      end
      if (c == FT - 1)
        for (int i = 0; i < CH; i++) act[i] = next_active(tgt[i], act[i]);
      if (load && !prev_load && int'(servo_address) < CH)
        tgt[servo_address] = int'(switch_duty_cycle);
      prev_load = load;
      @(negedge clock);
      for (int i = 0; i < CH; i++)
        if (servo_pwm_out[i] === 1'b1) hi[i]++;
      if (frame_start === 1'b1) begin
        fs_cnt++;
        if (fs_pos < 0) fs_pos = c;
      end
    end
    evq.delete();
    if (stop_at == FT) begin
      for (int i = 0; i < CH; i++) begin
        check($sformatf("%s ch%0d width", tag, i), hi[i], exp_w[i]);
        meas[i] = hi[i];
      end
      check($sformatf("%s frame_start count", tag), fs_cnt, 1);
      check($sformatf("%s frame_start pos", tag), fs_pos, 0);
    end
  endtask

  initial begin
    reset             = 1'b0;
    load              = 1'b0;
    servo_address     = '0;
    switch_duty_cycle = '0;
    hold_load         = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    check("reset pwm", int'(servo_pwm_out), 0);
    check("reset frame_start", int'(frame_start), 0);
    reset = 1'b1;

    // Idle frames at reset position
    run_frame(FT, "idle0");
    run_frame(FT, "idle1");
    for (int i = 0; i < CH; i++) check($sformatf("idle ch%0d 228", i), meas[i], 228);

    // Mid-frame writes to ch0 and ch3
    add_wr(300, 0, 0);
    add_wr(500, 3, 255);
    run_frame(FT, "wr_frame");
    for (int i = 0; i < CH; i++) check($sformatf("wr_frame ch%0d unchanged", i), meas[i], 228);
    run_frame(FT, "wr_next");
`ifndef SERVO_SLEW_EN
    check("ch0 min", meas[0], 100);
    check("ch3 max", meas[3], 355);
`endif
    check("ch1 untouched", meas[1], 228);
    check("ch2 untouched", meas[2], 228);

    // Held load with changing switches: single write on the rising edge
    hold_load = 1'b1;
    for (int f = 0; f < 5; f++) run_frame(FT, $sformatf("hold%0d", f));
    hold_load = 1'b0;
    run_frame(FT, "hold_end");

    // Boundary-cycle write versus a write one cycle earlier
    add_wr(100, 2, 10);
    add_wr(998, 1, 60);
    run_frame(FT, "bnd_a");
    add_wr(999, 2, 70);
    run_frame(FT, "bnd_b");
`ifndef SERVO_SLEW_EN
    check("bnd 998 applied", meas[1], 160);
    check("bnd ch2 preset", meas[2], 110);
`endif
    run_frame(FT, "bnd_c");
`ifndef SERVO_SLEW_EN
    check("bnd 999 deferred", meas[2], 110);
`endif
    run_frame(FT, "bnd_d");
`ifndef SERVO_SLEW_EN
    check("bnd 999 applied", meas[2], 170);
`endif

    // Randomized writes, last write per channel wins
    for (int f = 0; f < 6; f++) begin
      int n;
      n = int'($urandom_range(3, 1));
      for (int k = 0; k < n; k++)
        add_wr(k * 300 + int'($urandom_range(250, 0)), int'($urandom_range(CH - 1, 0)),
               int'($urandom_range(255, 0)));
      run_frame(FT, $sformatf("rand%0d", f));
    end

    // Asynchronous reset in mid-frame
    run_frame(51, "pre_reset");
    check("pre_reset high", int'(servo_pwm_out), 15);
    reset = 1'b0;
    #1;
    check("async reset pwm", int'(servo_pwm_out), 0);
    check("async reset frame_start", int'(frame_start), 0);
    load = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    run_frame(FT, "post_reset0");
    run_frame(FT, "post_reset1");
    for (int i = 0; i < CH; i++) check($sformatf("post_reset ch%0d 228", i), meas[i], 228);

    // 128 -> 140 on ch1: per-frame progression
    add_wr(200, 1, 140);
    run_frame(FT, "slew_wr");
    for (int f = 0; f < 4; f++) begin
      run_frame(FT, $sformatf("slew%0d", f));
      slew_w[f] = meas[1];
    end
`ifdef SERVO_SLEW_EN
    check("slew f1", slew_w[0], 232);
    check("slew f2", slew_w[1], 236);
    check("slew f3", slew_w[2], 240);
    check("slew f4", slew_w[3], 240);
`else
    check("jump f1", slew_w[0], 240);
    check("jump f2", slew_w[1], 240);
    check("jump f3", slew_w[2], 240);
    check("jump f4", slew_w[3], 240);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
